// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
//
// Shares one external combinational adder between NUM_REQ requesters.
// A round-robin search picks one valid requester and latches its operands.
// The adder is driven from those registered operands for one cycle, and the
// sum is captured. The sum and the requester index are then returned on a
// single response channel, which is held under backpressure.
//
// Ports
//   up_clk      clock
//   up_rst      asynchronous active-high reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept strobe (one-hot or zero)
//   req_a/b     packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   add_a/b     registered operands to the shared adder
//   add_sum     combinational sum returned by the shared adder
//   rsp_valid   response valid
//   rsp_ready   response accept
//   rsp_data    captured sum
//   rsp_id      index of the requester that issued the operation
//   busy        high whenever the sequencer is not idle
//   op_count    number of completed operations (wraps)
module adder_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          up_clk,
    input  logic                          up_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH-1:0]         add_sum,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          busy,
    output logic [31:0]                   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

    state_t                state_reg;
    logic [ID_WIDTH-1:0]   rr_ptr_reg;
    logic [DATA_WIDTH-1:0] op_a_reg;
    logic [DATA_WIDTH-1:0] op_b_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic [ID_WIDTH-1:0]   rsp_id_reg;
    logic                  rsp_valid_reg;
    logic                  busy_reg;
    logic [31:0]           op_count_reg;

    // Unpack the operand buses so the granted pair is a simple array read.
    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search. Rotate req_valid so rr_ptr lands on bit 0.
    // Then take the lowest set bit and add rr_ptr back, modulo NUM_REQ.
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [2*NUM_REQ-1:0] valid_shift;
    logic [NUM_REQ-1:0]   valid_rot;
    logic                 grant_found;
    logic [ID_WIDTH-1:0]  grant_offset;
    logic [ID_WIDTH:0]    grant_sum;
    logic [ID_WIDTH-1:0]  grant_idx;
    logic [ID_WIDTH:0]    ptr_inc;
    logic [ID_WIDTH-1:0]  rr_ptr_next;
    logic [NUM_REQ-1:0]   grant_onehot;

    assign valid_dbl   = {req_valid, req_valid};
    assign valid_shift = valid_dbl >> rr_ptr_reg;
    assign valid_rot   = valid_shift[NUM_REQ-1:0];

    always_comb begin
        grant_found  = 1'b0;
        grant_offset = '0;
        // Descending scan so the smallest offset wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                grant_found  = 1'b1;
                grant_offset = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_offset};
        if (grant_sum >= NUM_REQ_W) begin
            grant_sum = grant_sum - NUM_REQ_W;
        end
        grant_idx = grant_sum[ID_WIDTH-1:0];

        ptr_inc = {1'b0, grant_idx} + (ID_WIDTH+1)'(1);
        if (ptr_inc == NUM_REQ_W) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = ptr_inc[ID_WIDTH-1:0];
        end
    end

    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;

    // The accept strobe is combinational. It is gated off while reset is
    // asserted, because reset is asynchronous.
    assign req_ready = (state_reg == IDLE && grant_found && !up_rst)
                       ? grant_onehot : '0;

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            op_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        op_a_reg   <= a_arr[grant_idx];
                        op_b_reg   <= b_arr[grant_idx];
                        rsp_id_reg <= grant_idx;
                        rr_ptr_reg <= rr_ptr_next;
                        busy_reg   <= 1'b1;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    // The adder has seen the registered operands for the
                    // whole cycle, so its sum is settled here.
                    rsp_data_reg  <= add_sum;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        op_count_reg  <= op_count_reg + 32'd1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign add_a     = op_a_reg;
    assign add_b     = op_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = busy_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic           up_clk;
    logic           up_rst;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [DW-1:0]  add_a;
    logic [DW-1:0]  add_b;
    logic [DW-1:0]  add_sum;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DW-1:0]  rsp_data;
    logic [IW-1:0]  rsp_id;
    logic           busy;
    logic [31:0]    op_count;

    logic [DW-1:0]  tb_a [NR];
    logic [DW-1:0]  tb_b [NR];

    assign req_a   = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
    assign req_b   = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};
    // The shared adder lives outside the arbiter.
    assign add_sum = add_a + add_b;

    adder_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .up_clk    (up_clk),
        .up_rst    (up_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial up_clk = 1'b0;
    always #5 up_clk = ~up_clk;

    int total = 0;
    int bad   = 0;

    logic [IW+DW-1:0] exp_q [$];
    int hs_cyc_q [$];
    int grant_log [$];
    int grant_cyc [$];
    int cyc_n = 0;
    int rsp_seen = 0;
    int last_rsp_cycle = 0;
    logic [31:0] exp_count = 0;
    logic prev_rsp_valid = 1'b0;
    logic auto_drop = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Outputs are sampled at the falling edge. Accepts push
    // the model result, and responses pop it and compare. The task returns
    // 1ns after the rising edge.
    task automatic cyc();
        logic [NR-1:0] hs;
        logic [DW-1:0] s;
        int g;
        logic cnt_chk;
        g = -1;
        cnt_chk = 1'b0;
        @(negedge up_clk);
        hs = req_ready & req_valid;
        if (hs != '0) begin
            check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int i = 0; i < NR; i++) if (hs[i]) g = i;
            s = tb_a[g] + tb_b[g];
            exp_q.push_back({g[IW-1:0], s});
            hs_cyc_q.push_back(cyc_n);
            grant_log.push_back(g);
            grant_cyc.push_back(cyc_n);
            $display("cycle %0d: accept req%0d a=%08h b=%08h", cyc_n, g, tb_a[g], tb_b[g]);
        end
        if (rsp_valid && !prev_rsp_valid) begin
            if (hs_cyc_q.size() == 0) check("rsp_spurious", 64'(rsp_valid), 64'd0);
            else check("latency", 64'(cyc_n - hs_cyc_q[0]), 64'd2);
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                check("rsp_id", 64'(rsp_id), 64'(exp_q[0][IW+DW-1:DW]));
                check("rsp_data", 64'(rsp_data), 64'(exp_q[0][DW-1:0]));
                $display("cycle %0d: response id=%0d data=%08h", cyc_n, rsp_id, rsp_data);
                void'(exp_q.pop_front());
                void'(hs_cyc_q.pop_front());
                exp_count = exp_count + 32'd1;
                rsp_seen++;
                last_rsp_cycle = cyc_n;
                cnt_chk = 1'b1;
            end
        end
        prev_rsp_valid = rsp_valid;
        @(posedge up_clk);
        #1;
        cyc_n++;
        if (cnt_chk) check("op_count", 64'(op_count), 64'(exp_count));
        if (g >= 0 && auto_drop) req_valid[g] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int max_cyc);
        int target;
        target = rsp_seen + n;
        for (int i = 0; i < max_cyc && rsp_seen < target; i++) cyc();
        check("wait_rsp", 64'(rsp_seen), 64'(target));
    endtask

    task automatic wait_grants(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && grant_log.size() < n; i++) cyc();
        check("wait_grant", 64'(grant_log.size()), 64'(n));
    endtask

    initial begin
        up_rst    = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < NR; i++) begin
            tb_a[i] = '0;
            tb_b[i] = '0;
        end
        #12;
        // Reset state. req_ready is forced low even with every request valid.
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        req_valid = '0;
        @(posedge up_clk);
        #1;
        up_rst = 1'b0;

        // Single request 5 + 7 from requester 0.
        tb_a[0] = 32'd5;
        tb_b[0] = 32'd7;
        req_valid[0] = 1'b1;
        cyc();
        check("exec_busy", 64'(busy), 64'd1);
        check("exec_add_a", 64'(add_a), 64'd5);
        check("exec_add_b", 64'(add_b), 64'd7);
        check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        wait_rsp(1, 10);
        check("single_count", 64'(op_count), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        // Carry-out is discarded. rr_ptr is now 1, and only req1 is valid.
        tb_a[1] = 32'hFFFF_FFFF;
        tb_b[1] = 32'd2;
        req_valid[1] = 1'b1;
        wait_rsp(1, 10);

        // Clean reset, then all four requesters stay valid.
        up_rst = 1'b1;
        exp_count = '0;
        cyc();
        up_rst = 1'b0;
        prev_rsp_valid = 1'b0;
        grant_log.delete();
        grant_cyc.delete();
        for (int i = 0; i < NR; i++) begin
            tb_a[i] = $urandom;
            tb_b[i] = $urandom;
        end
        auto_drop = 1'b0;
        req_valid = 4'hF;
        wait_grants(6, 40);
        req_valid = '0;
        auto_drop = 1'b1;
        wait_rsp(exp_q.size(), 10);
        for (int i = 0; i < grant_log.size(); i++)
            check("rr_order", 64'(grant_log[i]), 64'(i % NR));
        for (int i = 1; i < grant_cyc.size(); i++)
            check("rr_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd3);

        // Pointer fairness. Grant req2 first, then raise req1 and req3.
        grant_log.delete();
        grant_cyc.delete();
        req_valid[2] = 1'b1;
        wait_grants(1, 10);
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        wait_grants(3, 20);
        wait_rsp(exp_q.size(), 10);
        if (grant_log.size() == 3) begin
            check("fair_g0", 64'(grant_log[0]), 64'd2);
            check("fair_g1", 64'(grant_log[1]), 64'd3);
            check("fair_g2", 64'(grant_log[2]), 64'd1);
        end

        // Backpressure while req0 is requesting again.
        grant_log.delete();
        grant_cyc.delete();
        rsp_ready = 1'b0;
        tb_a[0] = 32'h1234_5678;
        tb_b[0] = 32'h1111_1111;
        req_valid[0] = 1'b1;
        wait_grants(1, 10);
        tb_a[0] = 32'hA5A5_0000;
        tb_b[0] = 32'h0000_5A5A;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10 && !rsp_valid; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            if (exp_q.size() > 0) begin
                check("bp_rsp_data", 64'(rsp_data), 64'(exp_q[0][DW-1:0]));
                check("bp_rsp_id", 64'(rsp_id), 64'(exp_q[0][IW+DW-1:DW]));
            end
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        check("bp_no_grant", 64'(grant_log.size()), 64'd1);
        rsp_ready = 1'b1;
        wait_rsp(1, 5);
        wait_grants(2, 5);
        if (grant_cyc.size() == 2)
            check("bp_next_accept", 64'(grant_cyc[1]), 64'(last_rsp_cycle + 1));
        wait_rsp(1, 10);

        // Reset during EXEC discards the in-flight operation.
        grant_log.delete();
        grant_cyc.delete();
        tb_a[2] = 32'd100;
        tb_b[2] = 32'd200;
        req_valid[2] = 1'b1;
        wait_grants(1, 10);
        up_rst = 1'b1;
        #1;
        check("rst_exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_exec_busy", 64'(busy), 64'd0);
        check("rst_exec_op_count", 64'(op_count), 64'd0);
        exp_q.delete();
        hs_cyc_q.delete();
        exp_count = '0;
        req_valid = '0;
        cyc();
        check("rst_exec_rsp_valid2", 64'(rsp_valid), 64'd0);
        up_rst = 1'b0;
        prev_rsp_valid = 1'b0;
        grant_log.delete();
        grant_cyc.delete();
        req_valid = 4'hF;
        cyc();
        req_valid = '0;
        check("post_rst_grants", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() == 1)
            check("post_rst_grant", 64'(grant_log[0]), 64'd0);
        wait_rsp(1, 10);
        check("final_count", 64'(op_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
